// File: rtl/key_entry_pkg.sv
// Shared key codes, state encoding and widths for the keypad entry block.
package key_entry_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NDIG_W = 3;
   localparam int unsigned KEY_W  = 5;
   localparam int unsigned CNT_W  = 8;

   localparam logic [KEY_W-1:0] KEY_DIG_MAX = 5'd9;
   localparam logic [KEY_W-1:0] KEY_ENTER   = 5'd16;
   localparam logic [KEY_W-1:0] KEY_BACK    = 5'd17;
   localparam logic [KEY_W-1:0] KEY_CLEAR   = 5'd18;

   typedef enum logic {
      IDLE = 1'b0,
      EDIT = 1'b1
   } state_t;

   function automatic logic is_digit(input logic [KEY_W-1:0] k);
      return k <= KEY_DIG_MAX;
   endfunction

endpackage

// File: rtl/key_edge.sv
// Registers the key-held level and flags its rising edge for one cycle.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic keyclk_i,
   output logic rise_c
);

   logic keyclk_q;

   always_ff @(posedge clk) begin
      if (rst) keyclk_q <= 1'b0;
      else     keyclk_q <= keyclk_i;
   end

   assign rise_c = keyclk_i & ~keyclk_q;

endmodule

// File: rtl/key_entry.sv
// Four-digit BCD keypad entry with edit/commit FSM.
// Optional edit blink enabled by defining KEY_ENTRY_BLINK_EN.
module key_entry
   import key_entry_pkg::*;
#(
   parameter logic [DATA_W-1:0] RESET_VAL = 16'h0005,
   parameter logic [CNT_W-1:0]  BLINK_DIV = 8'd49
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [KEY_W-1:0]  keyout,
   input  logic              keyclk,
   output logic [DATA_W-1:0] entry,
   output logic [DATA_W-1:0] value,
   output logic [NDIG_W-1:0] ndig,
   output logic              editing,
   output logic              commit,
   output logic              err,
   output logic              blank
);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   entry_q, entry_d;
   logic [DATA_W-1:0]   value_q, value_d;
   logic [NDIG_W-1:0]   ndig_q, ndig_d;
   logic                commit_q, commit_d;
   logic                err_q, err_d;
   logic                press_c;

   key_edge u_key_edge (
      .clk      (clk),
      .rst      (rst),
      .keyclk_i (keyclk),
      .rise_c   (press_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         entry_q  <= '0;
         value_q  <= RESET_VAL;
         ndig_q   <= '0;
         commit_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         value_q  <= value_d;
         ndig_q   <= ndig_d;
         commit_q <= commit_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      value_d  = value_q;
      ndig_d   = ndig_q;
      commit_d = 1'b0;
      err_d    = 1'b0;
      if (press_c) begin
         case (state_q)
            IDLE: begin
               if (is_digit(keyout)) begin
                  state_d = EDIT;
                  entry_d = {12'h000, keyout[3:0]};
                  ndig_d  = 3'd1;
               end
            end
            EDIT: begin
               if (is_digit(keyout)) begin
                  if (ndig_q < 3'd4) begin
                     entry_d = {entry_q[11:0], keyout[3:0]};
                     ndig_d  = ndig_q + 3'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (keyout == KEY_BACK) begin
                  if (ndig_q != 3'd0) begin
                     entry_d = {4'h0, entry_q[15:4]};
                     ndig_d  = ndig_q - 3'd1;
                  end
               end else if (keyout == KEY_ENTER) begin
                  if (ndig_q != 3'd0) begin
                     value_d  = entry_q;
                     commit_d = 1'b1;
                  end
                  entry_d = '0;
                  ndig_d  = '0;
                  state_d = IDLE;
               end else if (keyout == KEY_CLEAR) begin
                  entry_d = '0;
                  ndig_d  = '0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef KEY_ENTRY_BLINK_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blank_q, blank_d;
   logic             accept_c;

   // Any recognised key restarts the blink phase so the new digit is visible.
   assign accept_c = press_c &&
                     (is_digit(keyout) ||
                      (state_q == EDIT && (keyout == KEY_ENTER || keyout == KEY_BACK ||
                                           keyout == KEY_CLEAR)));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         blank_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      blank_d = blank_q;
      if (state_d == IDLE || accept_c) begin
         cnt_d   = '0;
         blank_d = 1'b0;
      end else if (cnt_q == BLINK_DIV) begin
         cnt_d   = '0;
         blank_d = ~blank_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign blank = blank_q;
`else
   assign blank = 1'b0;
`endif

   assign entry   = entry_q;
   assign value   = value_q;
   assign ndig    = ndig_q;
   assign editing = (state_q == EDIT);
   assign commit  = commit_q;
   assign err     = err_q;

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL take parameter RESET_VAL, default 16'h0005: committed BCD value loaded at reset.
REQ-002 SHALL take parameter BLINK_DIV, default 8'd49: half-period, in clk cycles minus one, of the edit blink.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: system clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port keyout, input, 5: key code from the keypad encoder.
REQ-007 SHALL have port keyclk, input, 1: synchronized key-held level from the encoder.
REQ-008 SHALL have port entry, output, 16: four-digit BCD edit buffer.
REQ-009 SHALL have port value, output, 16: last committed BCD value.
REQ-010 SHALL have port ndig, output, 3: digits currently in entry, 0..4.
REQ-011 SHALL have port editing, output, 1: high while in state EDIT.
REQ-012 SHALL have port commit, output, 1: one-cycle pulse when value updates.
REQ-013 SHALL have port err, output, 1: one-cycle pulse on a rejected digit.
REQ-014 SHALL have port blank, output, 1: display blank request.

Function
REQ-015 SHALL detect a key press as keyclk=1 with the registered previous keyclk=0, and sample keyout on that same edge; held keys SHALL NOT repeat.
REQ-016 SHALL decode keyout as follows: codes 0-9 are digits, 16 is ENTER, 17 is BACK, 18 is CLEAR; codes 10-15 and 19 are ignored.
REQ-017 SHALL implement the two-state FSM IDLE and EDIT; all outputs are registered and reflect a press one cycle after the detect edge.
REQ-018 IDLE+digit SHALL go to EDIT with entry={12'h000,d} and ndig=1.
REQ-019 IDLE+ENTER/BACK/CLEAR SHALL have no effect.
REQ-020 EDIT+digit with ndig<4 SHALL set entry={entry[11:0],d} and increment ndig.
REQ-021 EDIT+digit with ndig=4 SHALL leave entry unchanged and pulse err.
REQ-022 EDIT+BACK with ndig>0 SHALL set entry={4'h0,entry[15:4]} and decrement ndig; with ndig=0 it is a no-op; the state remains EDIT.
REQ-023 EDIT+ENTER with ndig>0 SHALL set value=entry, pulse commit, clear entry and ndig, and go to IDLE.
REQ-024 EDIT+ENTER with ndig=0 SHALL go to IDLE without commit.
REQ-025 EDIT+CLEAR SHALL clear entry and ndig and go to IDLE without commit; value is unchanged.
REQ-026 The commit and err pulses SHALL be high for exactly one cycle and SHALL NOT be asserted together.

Reset
REQ-027 When rst=1 SHALL set state=IDLE, entry=0, ndig=0, value=RESET_VAL, commit=err=editing=blank=0, previous-keyclk register=0, and blink counter=0.
REQ-028 Reset SHALL dominate any simultaneous key edge.
REQ-029 Reset SHALL abort an edit mid-entry without commit.
REQ-030 A key held through reset release SHALL be accepted on the first clock edge after reset deasserts.

Configuration
REQ-031 With KEY_ENTRY_BLINK_EN defined, an 8-bit counter SHALL run in EDIT, wrap at BLINK_DIV, and toggle blank on each wrap.
REQ-032 With KEY_ENTRY_BLINK_EN defined, the counter and blank SHALL be forced to 0 in IDLE and on any accepted key.
REQ-033 Without KEY_ENTRY_BLINK_EN, blank SHALL be constant 0 and no counter SHALL exist.

Structure
REQ-034 Package key_entry_pkg SHALL hold the key code constants (KEY_ENTER=5'd16, KEY_BACK=5'd17, KEY_CLEAR=5'd18) and the state enum {IDLE, EDIT}.
REQ-035 Sub-module key_edge SHALL register keyclk and output a one-cycle rise pulse; all other logic SHALL be in key_entry.

Verification
REQ-036 Reset, then no presses -> value=16'h0005, entry=0, ndig=0, editing=0, commit=0.
REQ-037 Press 1,2,3, then ENTER -> entry 16'h0123 and ndig=3 before ENTER; after ENTER, value=16'h0123, commit high for 1 cycle, editing=0.
REQ-038 Press 9,8,7,6,5 -> entry=16'h9876, err pulses once on the 5th press, ndig=4.
REQ-039 Press 4,7, BACK, BACK, BACK, then ENTER -> entry 16'h0047, 16'h0004, 16'h0000, 16'h0000; ENTER gives IDLE with no commit and value unchanged.
REQ-040 Press 5 and hold keyclk high for 20 cycles, then press CLEAR -> exactly one digit accepted (entry=16'h0005), CLEAR returns IDLE with value unchanged.
REQ-041 Press 2, then assert rst on the same cycle as an ENTER edge -> value=RESET_VAL and no commit pulse; with KEY_ENTRY_BLINK_EN, blank toggles every 50 cycles during EDIT.
